// File: rtl/ham_dec_if.sv
// Port bundle for the dual-port SECDED Hamming decoder ham_dec.
// Holds the a/b encoded inputs, decoded outputs and error counters.
interface ham_dec_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ENCODED_WORD = 38,
  parameter int SYN_W        = $clog2(ENCODED_WORD + 1),
  parameter int CNT_W        = 16
);
  logic                    i_valid_a;
  logic                    i_valid_b;
  logic [ENCODED_WORD+1:1] i_hamming_a;
  logic [ENCODED_WORD+1:1] i_hamming_b;
  logic                    i_clr_cnt;
  logic                    o_valid_a;
  logic                    o_valid_b;
  logic [DATA_WIDTH-1:0]   o_data_a;
  logic [DATA_WIDTH-1:0]   o_data_b;
  logic                    o_serr_a;
  logic                    o_serr_b;
  logic                    o_derr_a;
  logic                    o_derr_b;
  logic [SYN_W-1:0]        o_syndrome_a;
  logic [SYN_W-1:0]        o_syndrome_b;
  logic [CNT_W-1:0]        o_serr_cnt_a;
  logic [CNT_W-1:0]        o_serr_cnt_b;
  logic [CNT_W-1:0]        o_derr_cnt_a;
  logic [CNT_W-1:0]        o_derr_cnt_b;

  modport master (
    output i_valid_a, i_valid_b,
    output i_hamming_a, i_hamming_b,
    output i_clr_cnt,
    input  o_valid_a, o_valid_b,
    input  o_data_a, o_data_b,
    input  o_serr_a, o_serr_b,
    input  o_derr_a, o_derr_b,
    input  o_syndrome_a, o_syndrome_b,
    input  o_serr_cnt_a, o_serr_cnt_b,
    input  o_derr_cnt_a, o_derr_cnt_b
  );

  modport slave (
    input  i_valid_a, i_valid_b,
    input  i_hamming_a, i_hamming_b,
    input  i_clr_cnt,
    output o_valid_a, o_valid_b,
    output o_data_a, o_data_b,
    output o_serr_a, o_serr_b,
    output o_derr_a, o_derr_b,
    output o_syndrome_a, o_syndrome_b,
    output o_serr_cnt_a, o_serr_cnt_b,
    output o_derr_cnt_a, o_derr_cnt_b
  );
endinterface

// File: rtl/ham_dec.sv
// Dual-port SECDED Hamming decoder, 2-stage pipeline per port.
// Define HAM_DEC_ERR_CNT_EN to build the saturating error counters.
module ham_dec #(
  parameter int DATA_WIDTH   = 32,
  parameter int ENCODED_WORD = 38,
  parameter int SYN_W        = $clog2(ENCODED_WORD + 1),
  parameter int CNT_W        = 16
) (
  input logic     i_clk,
  input logic     i_rst,
  ham_dec_if.slave bus
);
  localparam int HW = ENCODED_WORD + 1;
  localparam logic [SYN_W-1:0] SMAX = SYN_W'(ENCODED_WORD);

  function automatic logic [SYN_W-1:0] syndrome(
    input logic [HW:1] w
  );
    logic [SYN_W-1:0] s;
    s = '0;
    for (int i = 1; i <= ENCODED_WORD; i++)
      if (w[i]) s ^= SYN_W'(i);
    return s;
  endfunction

  // Data occupies non-power-of-2 positions, MSB at the top.
  function automatic logic [DATA_WIDTH-1:0] extract(
    input logic [HW:1] w
  );
    logic [DATA_WIDTH-1:0] d;
    int k;
    d = '0;
    k = DATA_WIDTH - 1;
    for (int p = ENCODED_WORD; p >= 3; p--) begin
      if ((p & (p - 1)) != 0) begin
        if (k >= 0) d[k] = w[p];
        k--;
      end
    end
    return d;
  endfunction

  logic          vin [2];
  logic [HW:1]   hin [2];

  assign vin[0] = bus.i_valid_a;
  assign vin[1] = bus.i_valid_b;
  assign hin[0] = bus.i_hamming_a;
  assign hin[1] = bus.i_hamming_b;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  v1;
    logic [HW:1]           w1;
    logic [SYN_W-1:0]      s1;
    logic                  q1;
    logic [HW:1]           fix;
    logic                  flip;
    logic                  serr_n;
    logic                  derr_n;
    logic                  v2;
    logic [DATA_WIDTH-1:0] data;
    logic                  serr;
    logic                  derr;
    logic [SYN_W-1:0]      syn;
    logic [CNT_W-1:0]      scnt;
    logic [CNT_W-1:0]      dcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v1 <= 1'b0;
        w1 <= '0;
        s1 <= '0;
        q1 <= 1'b0;
      end else begin
        v1 <= vin[p];
        if (vin[p]) begin
          w1 <= hin[p];
          s1 <= syndrome(hin[p]);
          q1 <= ^hin[p];
        end
      end
    end

    always_comb begin
      flip   = q1 && (s1 != '0) && (s1 <= SMAX);
      serr_n = q1 && (s1 <= SMAX);
      derr_n = ((s1 != '0) && !q1) || (q1 && (s1 > SMAX));
      fix    = w1;
      if (flip) fix[s1] = ~w1[s1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v2   <= 1'b0;
        data <= '0;
        serr <= 1'b0;
        derr <= 1'b0;
        syn  <= '0;
      end else begin
        v2 <= v1;
        if (v1) begin
          data <= extract(fix);
          serr <= serr_n;
          derr <= derr_n;
          syn  <= s1;
        end
      end
    end

`ifdef HAM_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] dc;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sc <= '0;
        dc <= '0;
      end else if (bus.i_clr_cnt) begin
        sc <= '0;
        dc <= '0;
      end else begin
        if (v1 && serr_n && !(&sc))
          sc <= sc + CNT_W'(1);
        if (v1 && derr_n && !(&dc))
          dc <= dc + CNT_W'(1);
      end
    end

    assign scnt = sc;
    assign dcnt = dc;
`else
    assign scnt = '0;
    assign dcnt = '0;
`endif
  end

`ifndef HAM_DEC_ERR_CNT_EN
  logic unused_clr;
  assign unused_clr = bus.i_clr_cnt;
`endif

  assign bus.o_valid_a    = g_port[0].v2;
  assign bus.o_valid_b    = g_port[1].v2;
  assign bus.o_data_a     = g_port[0].data;
  assign bus.o_data_b     = g_port[1].data;
  assign bus.o_serr_a     = g_port[0].serr;
  assign bus.o_serr_b     = g_port[1].serr;
  assign bus.o_derr_a     = g_port[0].derr;
  assign bus.o_derr_b     = g_port[1].derr;
  assign bus.o_syndrome_a = g_port[0].syn;
  assign bus.o_syndrome_b = g_port[1].syn;
  assign bus.o_serr_cnt_a = g_port[0].scnt;
  assign bus.o_serr_cnt_b = g_port[1].scnt;
  assign bus.o_derr_cnt_a = g_port[0].dcnt;
  assign bus.o_derr_cnt_b = g_port[1].dcnt;
endmodule

// File: tb/tb_ham_dec.sv
// Directed bench for ham_dec: clean, single, double, parity,
// dual-port burst, counter saturation/clear and mid-pipe reset.
module tb_ham_dec;
  localparam int DW = 32;
  localparam int EW = 38;
  localparam int SW = $clog2(EW + 1);
  localparam int CW = 16;
`ifdef HAM_DEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ham_dec_if #(
    .DATA_WIDTH(DW), .ENCODED_WORD(EW),
    .SYN_W(SW), .CNT_W(CW)
  ) bus ();

  ham_dec #(
    .DATA_WIDTH(DW), .ENCODED_WORD(EW),
    .SYN_W(SW), .CNT_W(CW)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW+1:1] enc(input logic [DW-1:0] d);
    logic [EW+1:1] w;
    int k;
    w = '0;
    k = DW - 1;
    for (int p = EW; p >= 3; p--)
      if ((p & (p - 1)) != 0) begin
        w[p] = d[k];
        k--;
      end
    for (int n = 0; n < SW; n++) begin
      logic b;
      b = 1'b0;
      if ((1 << n) <= EW) begin
        for (int p = 1; p <= EW; p++)
          if (p[n] && p != (1 << n)) b ^= w[p];
        w[1 << n] = b;
      end
    end
    w[EW+1] = ^w[EW:1];
    return w;
  endfunction

  function automatic logic [CW-1:0] ce(input int v);
    return CNT_EN ? CW'(v) : '0;
  endfunction

  task automatic send_a(input logic [EW+1:1] w);
    bus.i_valid_a   = 1'b1;
    bus.i_hamming_a = w;
    tick();
    bus.i_valid_a   = 1'b0;
    bus.i_hamming_a = '0;
    tick();
  endtask

  task automatic chk_a(
    input string tag, input logic [DW-1:0] d,
    input logic s, input logic e, input logic [SW-1:0] sy
  );
    chk({tag, "_v"},   bus.o_valid_a, 1'b1);
    chk({tag, "_d"},   bus.o_data_a, d);
    chk({tag, "_se"},  bus.o_serr_a, s);
    chk({tag, "_de"},  bus.o_derr_a, e);
    chk({tag, "_syn"}, bus.o_syndrome_a, sy);
  endtask

  logic [EW+1:1] w;
  logic [DW-1:0] da [8];
  logic [DW-1:0] db [8];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_valid_a   = 1'b0;
    bus.i_valid_b   = 1'b0;
    bus.i_hamming_a = '0;
    bus.i_hamming_b = '0;
    bus.i_clr_cnt   = 1'b0;
    tick();
    tick();
    chk("rst_va",  bus.o_valid_a, 1'b0);
    chk("rst_vb",  bus.o_valid_b, 1'b0);
    chk("rst_da",  bus.o_data_a, 32'h0);
    chk("rst_sa",  bus.o_serr_a, 1'b0);
    chk("rst_syn", bus.o_syndrome_b, 6'd0);
    chk("rst_cnt", bus.o_serr_cnt_a, 16'h0);
    rst = 1'b0;

    send_a(enc(32'hDEADBEEF));
    chk_a("clean", 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
    chk("clean_vb", bus.o_valid_b, 1'b0);
    tick();
    chk("clean_pulse", bus.o_valid_a, 1'b0);

    w = enc(32'h12345678);
    w[3] = ~w[3];
    send_a(w);
    chk_a("single", 32'h12345678, 1'b1, 1'b0, 6'd3);
    chk("single_cnt", bus.o_serr_cnt_a, ce(1));

    w = enc(32'h12345678);
    w[5] = ~w[5];
    w[9] = ~w[9];
    send_a(w);
    chk_a("double", 32'h1234566A, 1'b0, 1'b1, 6'd12);
    chk("double_cnt", bus.o_derr_cnt_a, ce(1));

    bus.i_hamming_a = {EW+1{1'b1}};
    tick();
    tick();
    tick();
    chk("hold_v", bus.o_valid_a, 1'b0);
    chk("hold_d", bus.o_data_a, 32'h1234566A);
    chk("hold_de", bus.o_derr_a, 1'b1);
    bus.i_hamming_a = '0;

    w = enc(32'hCAFEF00D);
    w[EW+1] = ~w[EW+1];
    send_a(w);
    chk_a("ovp", 32'hCAFEF00D, 1'b1, 1'b0, 6'd0);
    chk("ovp_cnt", bus.o_serr_cnt_a, ce(2));

    w = enc(32'h0BADF00D);
    w[32] = ~w[32];
    w[16] = ~w[16];
    w[1]  = ~w[1];
    send_a(w);
    chk_a("big_syn", 32'h0BADF00D, 1'b0, 1'b1, 6'd49);
    chk("big_cnt", bus.o_derr_cnt_a, ce(2));

    bus.i_clr_cnt = 1'b1;
    tick();
    bus.i_clr_cnt = 1'b0;
    chk("clr_sa", bus.o_serr_cnt_a, 16'h0);
    chk("clr_da", bus.o_derr_cnt_a, 16'h0);

    for (int k = 0; k < 8; k++) begin
      da[k] = 32'hA5A50000 + DW'(k * 17);
      db[k] = 32'h0F0F00FF ^ (DW'(k) << 8);
    end
    for (int t = 0; t <= 8; t++) begin
      if (t < 8) begin
        bus.i_valid_a   = 1'b1;
        bus.i_valid_b   = 1'b1;
        w = enc(da[t]);
        w[t+1] = ~w[t+1];
        bus.i_hamming_a = w;
        w = enc(db[t]);
        w[38-t] = ~w[38-t];
        bus.i_hamming_b = w;
      end else begin
        bus.i_valid_a = 1'b0;
        bus.i_valid_b = 1'b0;
      end
      tick();
      if (t >= 1) begin
        chk("bur_va", bus.o_valid_a, 1'b1);
        chk("bur_vb", bus.o_valid_b, 1'b1);
        chk("bur_da", bus.o_data_a, da[t-1]);
        chk("bur_db", bus.o_data_b, db[t-1]);
        chk("bur_sa", bus.o_serr_a, 1'b1);
        chk("bur_sb", bus.o_serr_b, 1'b1);
        chk("bur_ya", bus.o_syndrome_a, 64'(t));
        chk("bur_yb", bus.o_syndrome_b, 64'(39 - t));
      end
    end
    tick();
    chk("bur_cnta", bus.o_serr_cnt_a, ce(8));
    chk("bur_cntb", bus.o_serr_cnt_b, ce(8));
    chk("bur_dcb", bus.o_derr_cnt_b, 16'h0);

    bus.i_clr_cnt = 1'b1;
    tick();
    bus.i_clr_cnt = 1'b0;
    w = enc(32'h55AA33CC);
    w[3] = ~w[3];
    bus.i_hamming_a = w;
    bus.i_valid_a   = 1'b1;
    for (int n = 0; n < 65537; n++) tick();
    bus.i_valid_a = 1'b0;
    tick();
    tick();
    chk("sat_cnt", bus.o_serr_cnt_a, ce(16'hFFFF));
    chk("sat_d", bus.o_data_a, 32'h55AA33CC);

    bus.i_valid_a = 1'b1;
    tick();
    bus.i_valid_a = 1'b0;
    bus.i_clr_cnt = 1'b1;
    tick();
    bus.i_clr_cnt = 1'b0;
    chk("clrpri_v", bus.o_valid_a, 1'b1);
    chk("clrpri_s", bus.o_serr_a, 1'b1);
    chk("clrpri_c", bus.o_serr_cnt_a, 16'h0);

    w = enc(32'h87654321);
    w[7] = ~w[7];
    bus.i_hamming_a = w;
    bus.i_valid_a   = 1'b1;
    tick();
    bus.i_valid_a = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("mid_rst_v", bus.o_valid_a, 1'b0);
      chk("mid_rst_c", bus.o_serr_cnt_a, 16'h0);
    end
    chk("mid_rst_d", bus.o_data_a, 32'h0);

    send_a(enc(32'h00C0FFEE));
    chk_a("post_rst", 32'h00C0FFEE, 1'b0, 1'b0, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
